// File: rtl/uart_pkg.sv
// UART register map and status bit positions, shared by the UART and its clients.
package uart_pkg;
  localparam logic [7:0] UART_CTRL   = 8'h00;
  localparam logic [7:0] UART_STATUS = 8'h04;
  localparam logic [7:0] UART_BAUD   = 8'h08;
  localparam logic [7:0] UART_TXDATA = 8'h0C;
  localparam logic [7:0] UART_RXDATA = 8'h10;
  localparam int         UART_BUSY_BIT = 0;
endpackage

// File: rtl/uart_tx_fifo_pkg.sv
// CPU-side register map of the UART transmit FIFO front-end.
package uart_tx_fifo_pkg;
  localparam logic [7:0] REG_TXDATA   = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_IRQ_CTRL = 8'h08;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef struct packed {
    logic push;
    logic ovf_clr;
  } cpu_wr_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty reflect the registered count, so a push while
// full is rejected even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output logic [W-1:0] head
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-facing transmit FIFO that drains into a UART register port.
// Optional IRQ_CTRL register and irq_o output under macro UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo
  import uart_pkg::*;
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        uart_we_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic [31:0] uart_data_i
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE, S_CONFIRM} state_t;

  state_t      state_q, state_d;
  cpu_wr_t     wr;
  logic [7:0]  reg_addr;
  logic        full, empty, ovf, pop, uart_busy;
  logic [AW:0] count;
  logic [7:0]  head;
  logic        unused_bits;

  assign reg_addr    = addr_i[7:0];
  assign uart_busy   = uart_data_i[UART_BUSY_BIT];
  assign unused_bits = ^{addr_i[31:8], data_i[31:8], uart_data_i[31:1]};

  always_comb begin
    wr = '0;
    if (we_i) begin
      case (reg_addr)
        REG_TXDATA: wr.push    = 1'b1;
        REG_STATUS: wr.ovf_clr = data_i[ST_OVF];
        default: ;
      endcase
    end
  end

  // Head is released only once CONFIRM sees the UART busy with our byte.
  assign pop = (state_q == S_CONFIRM) & uart_busy;

  sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr.push),
    .pop   (pop),
    .din   (data_i[7:0]),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst)                  ovf <= 1'b0;
    else if (wr.push && full) ovf <= 1'b1;
    else if (wr.ovf_clr)      ovf <= 1'b0;
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (we_i && reg_addr == REG_IRQ_CTRL) irq_en <= data_i[0];
      irq_o <= irq_en & empty;
    end
  end
`endif

  always_comb begin
    data_o = '0;
    case (reg_addr)
      REG_STATUS: begin
        data_o[ST_FULL]                 = full;
        data_o[ST_EMPTY]                = empty;
        data_o[ST_OVF]                  = ovf;
        data_o[ST_COUNT_LSB +: AW+1]    = count;
      end
`ifdef UART_TX_FIFO_IRQ_EN
      REG_IRQ_CTRL: data_o[0] = irq_en;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!empty) state_d = S_POLL;
      S_POLL:    if (!uart_busy) state_d = S_WRITE;
      S_WRITE:   state_d = S_CONFIRM;
      S_CONFIRM: state_d = uart_busy ? S_IDLE : S_POLL;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    uart_we_o   = 1'b0;
    uart_addr_o = {24'h0, UART_STATUS};
    uart_data_o = '0;
    if (state_q == S_WRITE) begin
      uart_we_o   = 1'b1;
      uart_addr_o = {24'h0, UART_TXDATA};
      uart_data_o = {24'h0, head};
    end
  end
endmodule
